// File: rtl/mem_req_pkg.sv
// Shared types and helpers for the data-memory request engine: size
// encodings, the per-request tracking metadata and the byte-lane helpers.
package mem_req_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Per-request bookkeeping needed to shape the response. The tag travels
  // beside it because its width is a module parameter.
  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lo;
  } trk_meta_t;

  function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      SZ_B:    s = 4'b0001 << lo;
      SZ_H:    s = 4'b0011 << {lo[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Move the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                              input logic [1:0] lo, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(rdata >> {lo, 3'b000});
    h = 16'(rdata >> {lo[1], 4'b0000});
    case (size)
      SZ_B:    r = {{24{b[7] & ~uns}}, b};
      SZ_H:    r = {{16{h[15] & ~uns}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// In-order tracking queue for requests whose address phase is done and
// whose data phase is still pending. A discard-all input marks every
// stored entry so its eventual response is swallowed.
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [TAG_W-1:0] push_tag_i,
  input  trk_meta_t        push_meta_i,
  input  logic             push_discard_i,
  input  logic             pop_i,
  input  logic             discard_all_i,
  output logic [TAG_W-1:0] head_tag_o,
  output trk_meta_t        head_meta_o,
  output logic             head_discard_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] disc_q, disc_d;
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  trk_meta_t        meta_mem [DEPTH];
  logic             pop_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // A pop against an empty queue is a bus protocol error; it is dropped.
  assign pop_eff = pop_i && (cnt_q != '0);

  // Next pointers, occupancy and discard flags.
  always_comb begin
    wptr_d = push_i  ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop_eff ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    if (push_i && !pop_eff)      cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_eff) cnt_d = cnt_q - 1'b1;
    disc_d = discard_all_i ? '1 : disc_q;
    if (push_i) disc_d[wptr_q] = push_discard_i | discard_all_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; contents only matter while the entry is occupied.
  always_ff @(posedge clk) begin
    disc_q <= disc_d;
    if (push_i) begin
      tag_mem[wptr_q]  <= push_tag_i;
      meta_mem[wptr_q] <= push_meta_i;
    end
  end

  assign head_tag_o     = tag_mem[rptr_q];
  assign head_meta_o    = meta_mem[rptr_q];
  assign head_discard_o = disc_q[rptr_q];
  assign count_o        = cnt_q;
  assign empty_o        = (cnt_q == '0);

endmodule

// File: rtl/mem_req_unit.sv
// Data-memory request engine: registers one load/store at a time onto an
// SRAM-like req/addr_ok/data_ok bus, tracks up to DEPTH address-accepted
// requests and returns aligned, extended load data in order. Misaligned
// ops are consumed immediately and reported on the ALE outputs.
module mem_req_unit
  import mem_req_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wr,
  input  logic [1:0]       in_size,
  input  logic             in_unsigned,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_wdata,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             data_sram_req,
  output logic             data_sram_wr,
  output logic [1:0]       data_sram_size,
  output logic [3:0]       data_sram_wstrb,
  output logic [31:0]      data_sram_addr,
  output logic [31:0]      data_sram_wdata,
  input  logic             data_sram_addr_ok,
  input  logic             data_sram_data_ok,
  input  logic [31:0]      data_sram_rdata,
  output logic             resp_valid,
  output logic             resp_wr,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             ale_valid,
  output logic [TAG_W-1:0] ale_tag,
  output logic [CNT_W-1:0] outstanding,
  output logic             idle
);

  logic             req_busy_q, req_busy_d;
  logic             cancel_q, cancel_d;
  logic             wr_q, uns_q;
  logic [1:0]       size_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       wstrb_q;
  logic [TAG_W-1:0] tag_q;

  logic             fifo_empty, head_disc;
  trk_meta_t        head_meta;
  logic [TAG_W-1:0] head_tag;
  logic [CNT_W-1:0] cnt;

  logic pop, slot_free, hs, accept, mis, accept_ok;

  assign mis       = is_misaligned(in_size, in_addr[1:0]);
  assign pop       = data_sram_data_ok && !fifo_empty;
  // A response leaving this cycle frees the slot the request would need.
  assign slot_free = (cnt < CNT_W'(DEPTH)) || pop;
  assign hs        = data_sram_req && data_sram_addr_ok;
  assign accept    = in_valid && in_ready;
  assign accept_ok = accept && !mis;

  assign in_ready      = !flush && (!req_busy_q || hs);
  assign data_sram_req = req_busy_q && slot_free;

  // Payload is only meaningful while a request is held; show zeros otherwise.
  assign data_sram_wr    = req_busy_q && wr_q;
  assign data_sram_size  = req_busy_q ? size_q  : 2'b00;
  assign data_sram_wstrb = req_busy_q ? wstrb_q : 4'b0000;
  assign data_sram_addr  = req_busy_q ? addr_q  : 32'h0;
  assign data_sram_wdata = req_busy_q ? wdata_q : 32'h0;

  assign ale_valid = accept && mis;
  assign ale_tag   = ale_valid ? in_tag : '0;

  // A flush in the response cycle suppresses it along with everything older.
  assign resp_valid = pop && !head_disc && !flush;
  assign resp_wr    = resp_valid && head_meta.wr;
  assign resp_data  = (resp_valid && !head_meta.wr) ?
                      load_extend(head_meta.size, head_meta.uns, head_meta.lo, data_sram_rdata) : 32'h0;
  assign resp_tag   = resp_valid ? head_tag : '0;

  assign outstanding = cnt;
  assign idle        = !req_busy_q && (cnt == '0);

  // Request-register occupancy and cancel tracking.
  always_comb begin
    req_busy_d = req_busy_q;
    cancel_d   = cancel_q;
    if (hs) begin
      req_busy_d = 1'b0;
      cancel_d   = 1'b0;
    end
    // A held request cannot be withdrawn, so flush only marks it.
    if (flush && req_busy_q && !hs) cancel_d = 1'b1;
    if (accept_ok) begin
      req_busy_d = 1'b1;
      cancel_d   = 1'b0;
    end
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_busy_q <= 1'b0;
      cancel_q   <= 1'b0;
    end else begin
      req_busy_q <= req_busy_d;
      cancel_q   <= cancel_d;
    end
  end

  // Request payload, captured once per accepted aligned op.
  always_ff @(posedge clk) begin
    if (accept_ok) begin
      wr_q    <= in_wr;
      size_q  <= in_size;
      uns_q   <= in_unsigned;
      addr_q  <= in_addr;
      wdata_q <= calc_wdata(in_size, in_wdata);
      wstrb_q <= in_wr ? calc_wstrb(in_size, in_addr[1:0]) : 4'b0000;
      tag_q   <= in_tag;
    end
  end

  mem_req_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push_i         (hs),
    .push_tag_i     (tag_q),
    .push_meta_i    ('{wr: wr_q, size: size_q, uns: uns_q, lo: addr_q[1:0]}),
    .push_discard_i (cancel_q | flush),
    .pop_i          (data_sram_data_ok),
    .discard_all_i  (flush),
    .head_tag_o     (head_tag),
    .head_meta_o    (head_meta),
    .head_discard_o (head_disc),
    .count_o        (cnt),
    .empty_o        (fifo_empty)
  );

  a_data_ok_needs_entry: assert property (@(posedge clk) disable iff (rst)
    !(data_sram_data_ok && fifo_empty));

endmodule

// File: tb/tb_mem_req_unit.sv
// Bench for mem_req_unit: directed scenarios followed by randomized traffic,
// all compared against a queue-based reference model of the request engine.
module tb_mem_req_unit;

  localparam int DEPTH = 2;
  localparam int TAG_W = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_wr, in_unsigned;
  logic [1:0]       in_size;
  logic [31:0]      in_addr, in_wdata;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             data_sram_req, data_sram_wr;
  logic [1:0]       data_sram_size;
  logic [3:0]       data_sram_wstrb;
  logic [31:0]      data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic             data_sram_addr_ok, data_sram_data_ok;
  logic             resp_valid, resp_wr;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             ale_valid;
  logic [TAG_W-1:0] ale_tag;
  logic [CNT_W-1:0] outstanding;
  logic             idle;

  always #5 clk = ~clk;

  mem_req_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_tag(in_tag),
    .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_data(resp_data), .resp_tag(resp_tag),
    .ale_valid(ale_valid), .ale_tag(ale_tag), .outstanding(outstanding), .idle(idle)
  );

  typedef struct {
    logic             wr;
    logic [1:0]       size;
    logic             uns;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [TAG_W-1:0] tag;
    logic             cancel;
    int               hs_cyc;
  } op_t;

  // Reference model: one op waiting for its address phase, then an ordered
  // list of ops waiting for data. A flush cancels every op already accepted.
  logic m_pend;
  op_t  m_pend_op;
  op_t  m_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc_obs = 0;
  int n_resp_obs = 0;

  logic        o_req, o_in_ready, o_ale_valid, o_rv, o_rwr, o_idle;
  logic [1:0]  o_size;
  logic [3:0]  o_wstrb;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [TAG_W-1:0] o_ale_tag, o_rtag;
  logic [CNT_W-1:0] o_out;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_load(input op_t o, input logic [31:0] rd);
    int unsigned lo, sh;
    logic [31:0] v;
    lo = o.addr % 4;
    if (o.size == 2'd0)      sh = lo;
    else if (o.size == 2'd1) sh = lo & 2;
    else                     sh = 0;
    v = rd >> (8 * sh);
    if (o.size == 2'd0) begin
      v = v & 32'hFF;
      if (!o.uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (o.size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!o.uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_wstrb(input op_t o);
    int unsigned lo;
    lo = o.addr % 4;
    if (!o.wr) return 32'h0;
    if (o.size == 2'd0) return 32'd1 << lo;
    if (o.size == 2'd1) return 32'd3 << (lo & 2);
    return 32'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input op_t o);
    if (o.size == 2'd0) return 32'h0101_0101 * {24'h0, o.wdata[7:0]};
    if (o.size == 2'd1) return 32'h0001_0001 * {16'h0, o.wdata[15:0]};
    return o.wdata;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return (addr % 2) != 0;
    if (size == 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  task automatic model_cycle();
    logic exp_pop, exp_req, exp_hs, exp_ready, acc, mis, rv;
    op_t  h, n;
    o_req = data_sram_req;   o_in_ready = in_ready;   o_ale_valid = ale_valid;
    o_ale_tag = ale_tag;     o_rv = resp_valid;       o_rwr = resp_wr;
    o_rdata = resp_data;     o_rtag = resp_tag;       o_idle = idle;
    o_size = data_sram_size; o_wstrb = data_sram_wstrb;
    o_addr = data_sram_addr; o_wdata = data_sram_wdata; o_out = outstanding;
    if (in_valid && in_ready) n_acc_obs++;
    if (resp_valid) n_resp_obs++;
    if (rst) begin
      m_pend = 1'b0;
      m_q.delete();
      return;
    end
    exp_pop = data_sram_data_ok && (m_q.size() > 0);
    exp_req = m_pend && ((m_q.size() < DEPTH) || exp_pop);
    chk("bus_req", 32'(data_sram_req), 32'(exp_req));
    if (exp_req) begin
      chk("bus_addr", data_sram_addr, m_pend_op.addr);
      chk("bus_wr", 32'(data_sram_wr), 32'(m_pend_op.wr));
      chk("bus_size", 32'(data_sram_size), 32'(m_pend_op.size));
      chk("bus_wstrb", 32'(data_sram_wstrb), exp_wstrb(m_pend_op));
      if (m_pend_op.wr) chk("bus_wdata", data_sram_wdata, exp_wdata(m_pend_op));
    end
    exp_hs    = exp_req && data_sram_addr_ok;
    exp_ready = !flush && (!m_pend || exp_hs);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = in_valid && exp_ready;
    mis = misaligned(in_size, in_addr);
    chk("ale_valid", 32'(ale_valid), 32'(acc && mis));
    if (acc && mis) chk("ale_tag", 32'(ale_tag), 32'(in_tag));
    chk("outstanding", 32'(outstanding), 32'(m_q.size()));
    chk("idle", 32'(idle), 32'(!m_pend && m_q.size() == 0));
    if (exp_pop) begin
      h  = m_q.pop_front();
      rv = !h.cancel && !flush;
      chk("resp_valid", 32'(resp_valid), 32'(rv));
      if (rv) begin
        chk("resp_tag", 32'(resp_tag), 32'(h.tag));
        chk("resp_wr", 32'(resp_wr), 32'(h.wr));
        chk("resp_data", resp_data, h.wr ? 32'h0 : exp_load(h, data_sram_rdata));
      end
    end else begin
      chk("resp_idle", 32'(resp_valid), 32'h0);
    end
    if (exp_hs) begin
      n = m_pend_op;
      n.cancel = n.cancel || flush;
      n.hs_cyc = cyc;
      m_q.push_back(n);
      m_pend = 1'b0;
    end
    if (flush) begin
      foreach (m_q[i]) m_q[i].cancel = 1'b1;
      m_pend_op.cancel = 1'b1;
    end
    if (acc && !mis) begin
      m_pend = 1'b1;
      m_pend_op = '{wr: in_wr, size: in_size, uns: in_unsigned, addr: in_addr,
                    wdata: in_wdata, tag: in_tag, cancel: 1'b0, hs_cyc: 0};
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_in();
    in_valid = 0; in_wr = 0; in_size = 0; in_unsigned = 0; in_addr = 0;
    in_wdata = 0; in_tag = 0; flush = 0;
    data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
  endtask

  task automatic offer(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [TAG_W-1:0] tag);
    in_valid = 1; in_wr = wr; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata; in_tag = tag;
  endtask

  // Accept, address phase next cycle, data phase the cycle after.
  task automatic load_flow(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                           input logic [TAG_W-1:0] tag, input logic [31:0] rd);
    idle_in(); offer(0, size, uns, addr, 0, tag); step();
    idle_in(); data_sram_addr_ok = 1; step();
    idle_in(); data_sram_data_ok = 1; data_sram_rdata = rd; step();
    idle_in();
  endtask

  initial begin
    int acc0, rsp0;
    logic [1:0] lo;
    idle_in();
    rst = 1;
    repeat (3) step();
    rst = 0;
    step();
    chk("rst_in_ready", 32'(o_in_ready), 32'h1);
    chk("rst_idle", 32'(o_idle), 32'h1);
    chk("rst_req", 32'(o_req), 32'h0);
    chk("rst_outstanding", 32'(o_out), 32'h0);

    // Word load: request one cycle after accept, response in data_ok cycle.
    idle_in(); offer(0, 2, 0, 32'h1000, 0, 8'd5); step();
    chk("t1_req_at_accept", 32'(o_req), 32'h0);
    idle_in(); data_sram_addr_ok = 1; step();
    chk("t1_req", 32'(o_req), 32'h1);
    chk("t1_addr", o_addr, 32'h1000);
    idle_in(); step();
    data_sram_data_ok = 1; data_sram_rdata = 32'h8899_AABB; step();
    chk("t1_rv", 32'(o_rv), 32'h1);
    chk("t1_data", o_rdata, 32'h8899_AABB);
    chk("t1_tag", 32'(o_rtag), 32'h5);

    // Byte loads, signed then unsigned.
    idle_in(); offer(0, 0, 0, 32'h1003, 0, 8'd1); step();
    idle_in(); data_sram_addr_ok = 1; step();
    chk("t2_wstrb", 32'(o_wstrb), 32'h0);
    chk("t2_size", 32'(o_size), 32'h0);
    idle_in(); data_sram_data_ok = 1; data_sram_rdata = 32'h8011_2233; step();
    chk("t2_lb", o_rdata, 32'hFFFF_FF80);
    load_flow(0, 1, 32'h1003, 8'd2, 32'h8011_2233);
    chk("t2_lbu", o_rdata, 32'h0000_0080);

    // Stores: halfword lanes, then back-to-back until the tracker fills.
    idle_in(); offer(1, 1, 0, 32'h2002, 32'h1234, 8'h10); step();
    idle_in(); offer(1, 2, 0, 32'h3000, 32'hCAFE_F00D, 8'h11); data_sram_addr_ok = 1; step();
    chk("t3_sh_wstrb", 32'(o_wstrb), 32'hC);
    chk("t3_sh_wdata", o_wdata, 32'h1234_1234);
    idle_in(); offer(1, 0, 0, 32'h3001, 32'hAB, 8'h12); data_sram_addr_ok = 1; step();
    idle_in(); data_sram_addr_ok = 1; step();
    chk("t3_req_held", 32'(o_req), 32'h0);
    chk("t3_outstanding", 32'(o_out), 32'h2);
    idle_in(); data_sram_addr_ok = 1; data_sram_data_ok = 1; step();
    chk("t3_req_freed", 32'(o_req), 32'h1);
    chk("t3_store_resp", 32'(o_rwr), 32'h1);
    idle_in(); data_sram_data_ok = 1; step();
    idle_in(); data_sram_data_ok = 1; step();
    idle_in(); step();

    // Misaligned word load.
    idle_in(); offer(0, 2, 0, 32'h1001, 0, 8'd9); step();
    chk("t4_ale", 32'(o_ale_valid), 32'h1);
    chk("t4_ale_tag", 32'(o_ale_tag), 32'h9);
    chk("t4_req", 32'(o_req), 32'h0);
    chk("t4_outstanding", 32'(o_out), 32'h0);
    idle_in(); step();
    chk("t4_req_after", 32'(o_req), 32'h0);

    // Flush with two loads outstanding and one pending.
    idle_in(); offer(0, 2, 0, 32'h100, 0, 8'h21); step();
    idle_in(); offer(0, 2, 0, 32'h104, 0, 8'h22); data_sram_addr_ok = 1; step();
    idle_in(); offer(0, 2, 0, 32'h108, 0, 8'h23); data_sram_addr_ok = 1; step();
    idle_in(); flush = 1; in_valid = 1; step();
    chk("t5_flush_ready", 32'(o_in_ready), 32'h0);
    idle_in(); data_sram_addr_ok = 1; data_sram_data_ok = 1; data_sram_rdata = 32'h1; step();
    chk("t5_rv0", 32'(o_rv), 32'h0);
    chk("t5_req", 32'(o_req), 32'h1);
    idle_in(); data_sram_data_ok = 1; step();
    chk("t5_rv1", 32'(o_rv), 32'h0);
    idle_in(); data_sram_data_ok = 1; step();
    chk("t5_rv2", 32'(o_rv), 32'h0);
    idle_in(); offer(0, 2, 0, 32'h300, 0, 8'h25); step();
    idle_in(); flush = 1; step();
    chk("t5_req_kept", 32'(o_req), 32'h1);
    idle_in(); data_sram_addr_ok = 1; step();
    chk("t5_req_until_ok", 32'(o_req), 32'h1);
    idle_in(); data_sram_data_ok = 1; step();
    chk("t5_cancel_rv", 32'(o_rv), 32'h0);
    load_flow(2, 0, 32'h200, 8'h24, 32'h1122_3344);
    chk("t5_after_rv", 32'(o_rv), 32'h1);
    chk("t5_after_data", o_rdata, 32'h1122_3344);
    chk("t5_after_tag", 32'(o_rtag), 32'h24);

    // Streaming: addr_ok every cycle, each data_ok two cycles after its addr_ok.
    acc0 = n_acc_obs;
    rsp0 = n_resp_obs;
    for (int i = 0; i < 20; i++) begin
      idle_in();
      if (i < 12) offer(0, 2, 0, 32'h400 + 32'(4 * i), 0, TAG_W'(8'h30 + i));
      data_sram_addr_ok = 1;
      data_sram_data_ok = (m_q.size() > 0) && (m_q[0].hs_cyc <= cyc - 2);
      data_sram_rdata = $urandom;
      step();
    end
    chk("t6_accepts", 32'(n_acc_obs - acc0), 32'd12);
    chk("t6_responses", 32'(n_resp_obs - rsp0), 32'd12);

    // Randomized traffic with occasional flush and one mid-stream reset.
    for (int i = 0; i < 4000; i++) begin
      idle_in();
      rst = (i == 2000 || i == 2001);
      in_valid = ($urandom_range(0, 99) < 60);
      in_wr = 1'($urandom_range(0, 1));
      in_size = 2'($urandom_range(0, 2));
      in_unsigned = 1'($urandom_range(0, 1));
      lo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (in_size == 2'd1) lo[0] = 1'b0;
        if (in_size == 2'd2) lo = 2'b00;
      end
      in_addr = ($urandom & 32'hFFFF_FFFC) | {30'h0, lo};
      in_wdata = $urandom;
      in_tag = TAG_W'($urandom);
      flush = ($urandom_range(0, 99) < 3);
      data_sram_addr_ok = ($urandom_range(0, 2) != 0);
      data_sram_data_ok = !rst && (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      data_sram_rdata = $urandom;
      step();
    end
    rst = 0;
    idle_in();
    for (int i = 0; i < 8; i++) begin
      data_sram_addr_ok = 1;
      data_sram_data_ok = (m_q.size() > 0);
      step();
    end
    idle_in();
    step();
    chk("final_idle", 32'(o_idle), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_req_unit.md
Name: mem_req_unit

Overview:
- Parametrised data-memory request engine for the execute/memory boundary; successor to the single-outstanding sram request logic.
- Accepts one load/store op per cycle and drives the SRAM-like bus (req/addr_ok/data_ok).
- Tracks up to DEPTH issued-but-unanswered requests and returns aligned, extended load data with its tag in order.
- Cancels in-flight results on flush and detects misaligned accesses (ALE).

Parameters:
DEPTH, 2, max requests accepted by addr_ok still awaiting data_ok (>=1)
TAG_W, 8, width of opaque per-op tag returned with response (dest reg, etc.)
CNT_W, $clog2(DEPTH+1), derived; width of outstanding count

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  op offered
in_ready  out  1  op accepted when in_valid && in_ready
in_wr  in  1  1=store, 0=load
in_size  in  2  0=byte, 1=half, 2=word
in_unsigned  in  1  load zero-extend when 1
in_addr  in  32  byte address
in_wdata  in  32  store data, low-aligned
in_tag  in  TAG_W  opaque tag
flush  in  1  exception/branch flush
data_sram_req  out  1  bus request
data_sram_wr  out  1  store request
data_sram_size  out  2  same encoding as in_size
data_sram_wstrb  out  4  byte strobes
data_sram_addr  out  32  address
data_sram_wdata  out  32  replicated store data
data_sram_addr_ok  in  1  address handshake
data_sram_data_ok  in  1  data/response return, in order
data_sram_rdata  in  32  load data
resp_valid  out  1  response pulse; consumer always accepts
resp_wr  out  1  response belongs to a store
resp_data  out  32  aligned load result (0 for stores)
resp_tag  out  TAG_W  tag of response
ale_valid  out  1  misaligned op consumed, no bus request
ale_tag  out  TAG_W  tag of misaligned op
outstanding  out  CNT_W  tracking FIFO occupancy
idle  out  1  no pending request and outstanding==0

Behaviour:
- State: request register (req_busy, cancel bit, payload) plus tracking FIFO of DEPTH entries {tag, wr, size, unsigned, addr[1:0], discard}.
- Reset: req_busy=0, FIFO empty, all outputs 0 except in_ready=1, idle=1.
- Accept: in_ready = !flush && (!req_busy || (data_sram_req && data_sram_addr_ok)).
- On accept of an aligned op, the payload is registered and req_busy=1; the bus request is visible the next cycle (1-cycle accept-to-req latency). Back-to-back ops are sustained when addr_ok returns each cycle.
- data_sram_req = req_busy && (outstanding < DEPTH), or a same-cycle pop frees a slot. Payload is stable while req_busy.
- addr_ok while req is high: req_busy cleared, unless refilled by a same-cycle accept. An entry is pushed with discard = cancel bit.
- data_ok: pops the head.
  - resp_valid = data_ok && !head.discard, combinational in the same cycle.
  - data_ok with FIFO empty is a protocol violation: ignored, simulation assertion fires.
- Same-cycle push and pop: occupancy unchanged. Wrap-around uses pointer modulo DEPTH.
- wstrb: byte 0001<<a[1:0]; half 0011<<{a[1],0}; word 1111. Loads drive wstrb=0.
- wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- Load alignment: shift rdata right by 8*addr[1:0] (half uses addr[1] only), then take 8/16/32 bits and sign- or zero-extend per unsigned.
- ALE: half with a[0]=1, or word with a[1:0]!=0.
  - ale_valid = in_valid && in_ready && misaligned; ale_tag = in_tag.
  - The op is consumed with no request and no FIFO entry.
- Flush (single cycle):
  - All FIFO entries get discard=1.
  - If req_busy, cancel=1. An asserted request is never withdrawn and completes its handshake; in-flight stores still write, so store commit ordering is the pipeline's responsibility.
  - in_ready=0 during the flush cycle.
  - An entry pushed in the flush cycle is discarded.
  - A data_ok in the flush cycle still pops, with resp_valid=0.
- Cancel bit clears when the cancelled request is pushed.
- rst mid-operation drops all tracking. The bus side must be reset concurrently.

Decomposition:
- Package mem_req_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W
  - tracking-entry struct
  - wstrb/wdata/load-extend functions
  - ALE predicate
- Sub-module mem_req_fifo: parametrised DEPTH in-order queue with push/pop/count and a discard-all input.

Test Plan:
- Load word 0x1000, tag 5; addr_ok on cycle 1, data_ok cycle 3 with rdata 0x8899AABB -> req high 1 cycle after accept; resp_valid cycle 3, data 0x8899AABB, tag 5.
- lb signed addr 0x1003, rdata 0x80112233 -> wstrb 0000, size 0, resp_data 0xFFFFFF80. Same with unsigned -> 0x00000080.
- sh addr 0x2002, wdata 0x1234, DEPTH=2 -> wstrb 1100, wdata 0x12341234. Three back-to-back stores with no data_ok -> outstanding=2, third req held low until first data_ok.
- lw addr 0x1001 -> ale_valid=1 same cycle, no data_sram_req, outstanding unchanged.
- Two loads outstanding plus one pending request, flush -> pending req stays high until addr_ok; all three data_ok produce resp_valid=0; next load after flush responds normally.
- Continuous addr_ok every cycle, data_ok 2 cycles later -> one op per cycle, in-order tags, FIFO wraps without loss.
